// File: rtl/tdc_bus_arbiter_if.sv
// TDC bus interface: config-write and result-read handshakes plus the chip-side
// address/data/strobe pins. The arbiter connects through the slave modport.
interface tdc_bus_arbiter_if #(
  parameter int DATA_W = 28,
  parameter int ADDR_W = 4
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_en;
  logic              ef1;
  logic              ef2;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_chan;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dout;
  logic              dout_oe;
  logic [DATA_W-1:0] din;
  logic              CSN;
  logic              WRN;
  logic              RDN;
  logic              busy;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_en, ef1, ef2, din,
    output wr_ack, rd_valid, rd_data, rd_chan, addr, dout, dout_oe, CSN, WRN, RDN, busy
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_en, ef1, ef2, din,
    input  wr_ack, rd_valid, rd_data, rd_chan, addr, dout, dout_oe, CSN, WRN, RDN, busy
  );
endinterface

// File: rtl/tdc_bus_arbiter.sv
// Shared TDC bus owner: arbitrates config writes against round-robin FIFO result
// reads and runs each grant as a fixed setup/strobe/hold cycle with flopped pins.
module tdc_bus_arbiter #(
  parameter int DATA_W     = 28,
  parameter int ADDR_W     = 4,
  parameter int STROBE_CYC = 1,
  parameter int HOLD_CYC   = 1,
  parameter int EF_BLANK   = 2,
  parameter int RD_ADDR1   = 8,
  parameter int RD_ADDR2   = 9
) (
  input  logic             clk,
  input  logic             reset,
  tdc_bus_arbiter_if.slave bus
);

  localparam int CMAX  = (STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BW    = (EF_BLANK > 0) ? $clog2(EF_BLANK + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              op_wr_q;
  logic              chan_q;
  logic              ptr_q;
  logic [1:0]        ef1_s_q, ef2_s_q;
  logic [BW-1:0]     blank1_q, blank1_d, blank2_q, blank2_d;

  logic              csn_q, wrn_q, rdn_q, oe_q, busy_q, wr_ack_q, rd_valid_q, rd_chan_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q, rd_data_q;

  logic req1, req2, grant2, strobe_last, rd_done;

  // Flags are async to clk; the blank window covers their stale period after a read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ef1_s_q <= 2'b11;
      ef2_s_q <= 2'b11;
    end else begin
      ef1_s_q <= {ef1_s_q[0], bus.ef1};
      ef2_s_q <= {ef2_s_q[0], bus.ef2};
    end
  end

  assign req1        = bus.rd_en & ~ef1_s_q[1] & (blank1_q == '0);
  assign req2        = bus.rd_en & ~ef2_s_q[1] & (blank2_q == '0);
  assign grant2      = req2 & (~req1 | ptr_q);
  assign strobe_last = (state_q == STROBE) && (cnt_q == '0);
  assign rd_done     = strobe_last & ~op_wr_q;

  always_comb begin
    blank1_d = blank1_q;
    blank2_d = blank2_q;
    if (rd_done && !chan_q)     blank1_d = BW'(EF_BLANK);
    else if (blank1_q != '0)    blank1_d = blank1_q - BW'(1);
    if (rd_done && chan_q)      blank2_d = BW'(EF_BLANK);
    else if (blank2_q != '0)    blank2_d = blank2_q - BW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank1_q <= '0;
      blank2_q <= '0;
    end else begin
      blank1_q <= blank1_d;
      blank2_q <= blank2_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_wr_q    <= 1'b0;
      chan_q     <= 1'b0;
      ptr_q      <= 1'b0;
      csn_q      <= 1'b1;
      wrn_q      <= 1'b1;
      rdn_q      <= 1'b1;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_chan_q  <= 1'b0;
      addr_q     <= '1;
      dout_q     <= '0;
      rd_data_q  <= '0;
    end else begin
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.wr_req) begin
            state_q <= SETUP;
            op_wr_q <= 1'b1;
            addr_q  <= bus.wr_addr;
            dout_q  <= bus.wr_data;
            oe_q    <= 1'b1;
            busy_q  <= 1'b1;
          end else if (req1 || req2) begin
            state_q <= SETUP;
            op_wr_q <= 1'b0;
            chan_q  <= grant2;
            addr_q  <= grant2 ? ADDR_W'(RD_ADDR2) : ADDR_W'(RD_ADDR1);
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          state_q <= STROBE;
          cnt_q   <= CNT_W'(STROBE_CYC - 1);
          csn_q   <= 1'b0;
          wrn_q   <= ~op_wr_q;
          rdn_q   <= op_wr_q;
        end
        STROBE: begin
          if (cnt_q == '0) begin
            state_q <= HOLD;
            cnt_q   <= CNT_W'(HOLD_CYC - 1);
            csn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            rdn_q   <= 1'b1;
            if (op_wr_q) begin
              wr_ack_q <= 1'b1;
            end else begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= bus.din;
              rd_chan_q  <= chan_q;
              ptr_q      <= ~chan_q;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            addr_q  <= '1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.CSN      = csn_q;
  assign bus.WRN      = wrn_q;
  assign bus.RDN      = rdn_q;
  assign bus.dout_oe  = oe_q;
  assign bus.addr     = addr_q;
  assign bus.dout     = dout_q;
  assign bus.busy     = busy_q;
  assign bus.wr_ack   = wr_ack_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_chan  = rd_chan_q;

endmodule

// File: tb/tb_tdc_bus_arbiter.sv
// Directed bench for tdc_bus_arbiter: write cycle, single read, round-robin,
// write/read contention, blank spacing and reset mid-strobe.
module tb_tdc_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;

  tdc_bus_arbiter_if #(.DATA_W(28), .ADDR_W(4)) bus ();

  tdc_bus_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.wr_req = 1'b0;
    bus.rd_en  = 1'b0;
    bus.ef1    = 1'b1;
    bus.ef2    = 1'b1;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Waits for the next rd_valid pulse, bounded; returns the cycle it was seen.
  task automatic wait_rd(input string tag, input logic exp_chan, input logic [27:0] exp_data,
                         output int at_cyc);
    bit found = 0;
    at_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      tick;
      if (bus.rd_valid) begin
        found = 1;
        at_cyc = cyc;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
    if (found) begin
      chk({tag, "_chan"}, 32'(bus.rd_chan), 32'(exp_chan));
      chk({tag, "_addr"}, 32'(bus.addr), exp_chan ? 32'd9 : 32'd8);
      chk({tag, "_data"}, 32'(bus.rd_data), 32'(exp_data));
    end
  endtask

  initial begin
    int t_prev, t_now;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.ef1     = 1'b1;
    bus.ef2     = 1'b1;
    bus.din     = '0;

    // reset state
    #12;
    chk("rst_csn",  32'(bus.CSN), 32'd1);
    chk("rst_wrn",  32'(bus.WRN), 32'd1);
    chk("rst_rdn",  32'(bus.RDN), 32'd1);
    chk("rst_oe",   32'(bus.dout_oe), 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'hF);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rv",   32'(bus.rd_valid), 32'd0);
    do_reset;

    // 1: config write
    bus.wr_req = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 28'h0E004DA;
    tick;
    chk("w_setup_addr", 32'(bus.addr), 32'd5);
    chk("w_setup_dout", 32'(bus.dout), 32'h0E004DA);
    chk("w_setup_oe",   32'(bus.dout_oe), 32'd1);
    chk("w_setup_csn",  32'(bus.CSN), 32'd1);
    chk("w_setup_busy", 32'(bus.busy), 32'd1);
    tick;
    chk("w_strb_csn", 32'(bus.CSN), 32'd0);
    chk("w_strb_wrn", 32'(bus.WRN), 32'd0);
    chk("w_strb_rdn", 32'(bus.RDN), 32'd1);
    chk("w_strb_ack", 32'(bus.wr_ack), 32'd0);
    tick;
    chk("w_hold_ack",  32'(bus.wr_ack), 32'd1);
    chk("w_hold_csn",  32'(bus.CSN), 32'd1);
    chk("w_hold_wrn",  32'(bus.WRN), 32'd1);
    chk("w_hold_addr", 32'(bus.addr), 32'd5);
    chk("w_hold_oe",   32'(bus.dout_oe), 32'd1);
    chk("w_hold_busy", 32'(bus.busy), 32'd1);
    bus.wr_req = 1'b0;
    tick;
    chk("w_idle_busy", 32'(bus.busy), 32'd0);
    chk("w_idle_ack",  32'(bus.wr_ack), 32'd0);
    chk("w_idle_oe",   32'(bus.dout_oe), 32'd0);
    chk("w_idle_addr", 32'(bus.addr), 32'hF);

    // 2: single FIFO1 read through the synchronizer
    bus.din = 28'h1234567; bus.rd_en = 1'b1; bus.ef1 = 1'b0;
    tick;
    chk("r_sync1_busy", 32'(bus.busy), 32'd0);
    tick;
    chk("r_sync2_busy", 32'(bus.busy), 32'd0);
    tick;
    chk("r_setup_addr", 32'(bus.addr), 32'd8);
    chk("r_setup_busy", 32'(bus.busy), 32'd1);
    chk("r_setup_oe",   32'(bus.dout_oe), 32'd0);
    tick;
    chk("r_strb_csn", 32'(bus.CSN), 32'd0);
    chk("r_strb_rdn", 32'(bus.RDN), 32'd0);
    chk("r_strb_wrn", 32'(bus.WRN), 32'd1);
    chk("r_strb_oe",  32'(bus.dout_oe), 32'd0);
    tick;
    chk("r_hold_rv",   32'(bus.rd_valid), 32'd1);
    chk("r_hold_data", 32'(bus.rd_data), 32'h1234567);
    chk("r_hold_chan", 32'(bus.rd_chan), 32'd0);
    chk("r_hold_rdn",  32'(bus.RDN), 32'd1);
    bus.rd_en = 1'b0; bus.ef1 = 1'b1;
    tick;
    chk("r_idle_rv", 32'(bus.rd_valid), 32'd0);

    // 3: both FIFOs non-empty alternate 8,9,8,9 four cycles apart
    do_reset;
    bus.din = 28'h0A5A5A5; bus.rd_en = 1'b1; bus.ef1 = 1'b0; bus.ef2 = 1'b0;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_rd($sformatf("rr%0d", k), k[0], 28'h0A5A5A5, t_now);
      if (k > 0) chk($sformatf("rr%0d_gap", k), 32'(t_now - t_prev), 32'd4);
      t_prev = t_now;
    end
    bus.rd_en = 1'b0;

    // 4: write and FIFO1 read contend in one IDLE cycle; write first
    do_reset;
    bus.din = 28'h0777777; bus.rd_en = 1'b1; bus.ef1 = 1'b0;
    tick;
    tick;
    bus.wr_req = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 28'h0ABCDEF;
    tick;
    chk("c_setup_addr", 32'(bus.addr), 32'd3);
    chk("c_setup_oe",   32'(bus.dout_oe), 32'd1);
    tick;
    chk("c_strb_wrn", 32'(bus.WRN), 32'd0);
    chk("c_strb_rdn", 32'(bus.RDN), 32'd1);
    tick;
    chk("c_ack", 32'(bus.wr_ack), 32'd1);
    bus.wr_req = 1'b0;
    t_prev = cyc;
    wait_rd("c_rd", 1'b0, 28'h0777777, t_now);
    chk("c_rd_gap", 32'(t_now - t_prev), 32'd4);
    bus.rd_en = 1'b0;

    // 5: FIFO1 alone, reads spaced by the blank window
    do_reset;
    bus.din = 28'h0000042; bus.rd_en = 1'b1; bus.ef1 = 1'b0;
    wait_rd("b_rd0", 1'b0, 28'h0000042, t_prev);
    tick;
    chk("b_idle1_busy", 32'(bus.busy), 32'd0);
    tick;
    chk("b_blank_busy", 32'(bus.busy), 32'd0);
    tick;
    chk("b_regrant_busy", 32'(bus.busy), 32'd1);
    chk("b_regrant_addr", 32'(bus.addr), 32'd8);
    wait_rd("b_rd1", 1'b0, 28'h0000042, t_now);
    chk("b_gap", 32'(t_now - t_prev), 32'd5);
    bus.rd_en = 1'b0;

    // 6: reset during read strobe
    do_reset;
    bus.din = 28'h0BEEF01; bus.rd_en = 1'b1; bus.ef1 = 1'b0;
    tick; tick; tick; tick;
    chk("x_strb_csn", 32'(bus.CSN), 32'd0);
    chk("x_strb_rdn", 32'(bus.RDN), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("x_async_csn",  32'(bus.CSN), 32'd1);
    chk("x_async_rdn",  32'(bus.RDN), 32'd1);
    chk("x_async_addr", 32'(bus.addr), 32'hF);
    chk("x_async_busy", 32'(bus.busy), 32'd0);
    tick;
    chk("x_rst_rv", 32'(bus.rd_valid), 32'd0);
    reset = 1'b0;
    tick;
    chk("x_sync1_busy", 32'(bus.busy), 32'd0);
    tick;
    chk("x_sync2_busy", 32'(bus.busy), 32'd0);
    tick;
    chk("x_setup_busy", 32'(bus.busy), 32'd1);
    chk("x_setup_addr", 32'(bus.addr), 32'd8);
    chk("x_setup_csn",  32'(bus.CSN), 32'd1);
    tick;
    chk("x_strb_rdn2", 32'(bus.RDN), 32'd0);
    tick;
    chk("x_rv",   32'(bus.rd_valid), 32'd1);
    chk("x_data", 32'(bus.rd_data), 32'h0BEEF01);
    bus.rd_en = 1'b0;
    tick;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
